// File: rtl/dac_wave_gen.sv
// dac_wave_gen: sawtooth-up/down, triangle and square DAC code generator with programmable step and update period.
// Optional build macro DAC_WAVE_SYNC_EN adds sync_in, an in-place restart of the waveform while running.
module dac_wave_gen #(
    parameter int DATA_W = 10,
    parameter int DIV_W  = 20
) (
    input  logic              s_clk,
    input  logic              s_rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [DIV_W-1:0]  step_div,
    input  logic [DATA_W-1:0] step_size,
`ifdef DAC_WAVE_SYNC_EN
    input  logic              sync_in,
`endif
    output logic [DATA_W-1:0] dac_data,
    output logic              dac_vld,
    output logic              cycle_done,
    output logic              busy,
    output logic [1:0]        state_dbg
);

    // dac_vld is a one-cycle strobe with no backpressure: the DAC must accept
    // dac_data on every cycle where dac_vld is high; cycle_done only ever
    // rises together with dac_vld.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [1:0]        M_SAW_UP = 2'd0;
    localparam logic [1:0]        M_SAW_DN = 2'd1;
    localparam logic [1:0]        M_TRI    = 2'd2;
    localparam logic [DATA_W-1:0] MAX      = {DATA_W{1'b1}};

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   phase_q, phase_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                dir_q, dir_d;          // 0 = up, 1 = down
    logic [1:0]          sh_mode_q, sh_mode_d;
    logic [DIV_W-1:0]    sh_div_q, sh_div_d;
    logic [DATA_W-1:0]   sh_step_q, sh_step_d;
    logic                vld_q, vld_d;
    logic                done_q, done_d;

    logic                sync_req;
    logic                tick;
    logic [DATA_W:0]     sum;
    logic [DATA_W:0]     diff;
    logic [DATA_W:0]     phase_sum;
    logic [DATA_W-1:0]   wave_data;
    logic [DATA_W-1:0]   wave_phase;
    logic                wave_dir;
    logic                wave_done;

`ifdef DAC_WAVE_SYNC_EN
    assign sync_req = sync_in;
`else
    assign sync_req = 1'b0;
`endif

    // One extra MSB on each operation carries the wrap (carry/borrow) bit.
    assign tick      = (div_q == sh_div_q);
    assign sum       = {1'b0, data_q} + {1'b0, sh_step_q};
    assign diff      = {1'b0, data_q} - {1'b0, sh_step_q};
    assign phase_sum = {1'b0, phase_q} + {1'b0, sh_step_q};

    // Waveform value the next tick would produce.
    always_comb begin
        wave_data  = data_q;
        wave_phase = phase_q;
        wave_dir   = dir_q;
        wave_done  = 1'b0;
        case (sh_mode_q)
            M_SAW_UP: begin
                wave_data = sum[DATA_W-1:0];
                wave_done = sum[DATA_W];
            end
            M_SAW_DN: begin
                wave_data = diff[DATA_W-1:0];
                wave_done = diff[DATA_W];
            end
            M_TRI: begin
                if (!dir_q) begin
                    if (data_q > (MAX - sh_step_q)) begin
                        wave_data = MAX;
                        wave_dir  = 1'b1;
                    end else begin
                        wave_data = sum[DATA_W-1:0];
                    end
                end else begin
                    if (data_q < sh_step_q) begin
                        wave_data = '0;
                        wave_dir  = 1'b0;
                        wave_done = 1'b1;
                    end else begin
                        wave_data = diff[DATA_W-1:0];
                    end
                end
            end
            default: begin
                wave_phase = phase_sum[DATA_W-1:0];
                if (phase_sum[DATA_W]) begin
                    wave_data = (data_q == MAX) ? '0 : MAX;
                    wave_done = (data_q == MAX);
                end
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        phase_d   = phase_q;
        div_d     = div_q;
        dir_d     = dir_q;
        sh_mode_d = sh_mode_q;
        sh_div_d  = sh_div_q;
        sh_step_d = sh_step_q;
        vld_d     = 1'b0;
        done_d    = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            data_d  = '0;
            phase_d = '0;
            div_d   = '0;
            dir_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_LOAD;
                ST_LOAD: begin
                    state_d   = ST_RUN;
                    sh_mode_d = mode;
                    sh_div_d  = step_div;
                    sh_step_d = step_size;
                    div_d     = '0;
                    phase_d   = '0;
                    dir_d     = 1'b0;
                    data_d    = (mode == M_SAW_DN) ? MAX : '0;
                end
                ST_RUN: begin
                    if (sync_req) begin
                        // In-place restart: keeps sh_mode, reloads step and period.
                        sh_div_d  = step_div;
                        sh_step_d = step_size;
                        div_d     = '0;
                        phase_d   = '0;
                        dir_d     = 1'b0;
                        data_d    = (sh_mode_q == M_SAW_DN) ? MAX : '0;
                    end else if (tick) begin
                        div_d   = '0;
                        data_d  = wave_data;
                        phase_d = wave_phase;
                        dir_d   = wave_dir;
                        vld_d   = 1'b1;
                        done_d  = wave_done;
                        if (wave_done) begin
                            sh_div_d  = step_div;
                            sh_step_d = step_size;
                        end
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            phase_q   <= '0;
            div_q     <= '0;
            dir_q     <= 1'b0;
            sh_mode_q <= '0;
            sh_div_q  <= '0;
            sh_step_q <= '0;
            vld_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            phase_q   <= phase_d;
            div_q     <= div_d;
            dir_q     <= dir_d;
            sh_mode_q <= sh_mode_d;
            sh_div_q  <= sh_div_d;
            sh_step_q <= sh_step_d;
            vld_q     <= vld_d;
            done_q    <= done_d;
        end
    end

    assign dac_data   = data_q;
    assign dac_vld    = vld_q;
    assign cycle_done = done_q;
    assign busy       = (state_q != ST_IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Bench for dac_wave_gen: arithmetic reference model checked every cycle plus directed literal checks.
// Build with DAC_WAVE_SYNC_EN defined to also exercise sync_in.
module tb_dac_wave_gen;

    localparam int DATA_W = 10;
    localparam int DIV_W  = 20;
    localparam int MAX    = (1 << DATA_W) - 1;

    logic              s_clk;
    logic              s_rst_n = 1'b0;
    logic              en = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [DIV_W-1:0]  step_div = '0;
    logic [DATA_W-1:0] step_size = '0;
`ifdef DAC_WAVE_SYNC_EN
    logic              sync_in = 1'b0;
`endif
    logic [DATA_W-1:0] dac_data;
    logic              dac_vld;
    logic              cycle_done;
    logic              busy;
    logic [1:0]        state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int tri_tbl[9]  = '{256, 512, 768, 1023, 767, 511, 255, 0, 256};
    int tri_done[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};

    dac_wave_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .s_clk      (s_clk),
        .s_rst_n    (s_rst_n),
        .en         (en),
        .mode       (mode),
        .step_div   (step_div),
        .step_size  (step_size),
`ifdef DAC_WAVE_SYNC_EN
        .sync_in    (sync_in),
`endif
        .dac_data   (dac_data),
        .dac_vld    (dac_vld),
        .cycle_done (cycle_done),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        s_clk = 1'b0;
        forever #5 s_clk = ~s_clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_stage: 0 idle, 1 loading, 2 running. m_wait counts cycles left before the next update.
    int m_stage = 0, m_data = 0, m_phase = 0, m_mode = 0, m_div = 0, m_step = 0, m_wait = 0;
    int m_vld = 0, m_done = 0, m_up = 1, nxt;

    always @(posedge s_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            m_stage = 0; m_data = 0; m_phase = 0; m_mode = 0; m_div = 0; m_step = 0;
            m_wait = 0; m_vld = 0; m_done = 0; m_up = 1;
        end else begin
            m_vld = 0;
            m_done = 0;
            if (!en) begin
                m_stage = 0; m_data = 0; m_phase = 0; m_up = 1; m_wait = 0;
            end else if (m_stage == 0) begin
                m_stage = 1;
            end else if (m_stage == 1) begin
                m_stage = 2;
                m_mode = int'(mode); m_div = int'(step_div); m_step = int'(step_size);
                m_wait = m_div; m_phase = 0; m_up = 1;
                m_data = (m_mode == 1) ? MAX : 0;
            end
`ifdef DAC_WAVE_SYNC_EN
            else if (sync_in) begin
                m_div = int'(step_div); m_step = int'(step_size);
                m_wait = m_div; m_phase = 0; m_up = 1;
                m_data = (m_mode == 1) ? MAX : 0;
            end
`endif
            else if (m_wait > 0) begin
                m_wait = m_wait - 1;
            end else begin
                m_vld = 1;
                case (m_mode)
                    0: begin
                        nxt = m_data + m_step;
                        m_done = (nxt > MAX) ? 1 : 0;
                        m_data = nxt % (MAX + 1);
                    end
                    1: begin
                        m_done = (m_step > m_data) ? 1 : 0;
                        m_data = (m_data - m_step + MAX + 1) % (MAX + 1);
                    end
                    2: begin
                        if (m_up == 1) begin
                            if (m_data + m_step > MAX) begin m_data = MAX; m_up = 0; end
                            else m_data = m_data + m_step;
                        end else begin
                            if (m_data < m_step) begin m_data = 0; m_up = 1; m_done = 1; end
                            else m_data = m_data - m_step;
                        end
                    end
                    default: begin
                        nxt = m_phase + m_step;
                        if (nxt > MAX) begin
                            m_phase = nxt - (MAX + 1);
                            m_done = (m_data == MAX) ? 1 : 0;
                            m_data = MAX - m_data;
                        end else begin
                            m_phase = nxt;
                        end
                    end
                endcase
                if (m_done == 1) begin
                    m_div = int'(step_div);
                    m_step = int'(step_size);
                end
                m_wait = m_div;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge s_clk) begin
        if (chk_en) begin
            check("cmp_data", int'(dac_data), m_data);
            check("cmp_vld", int'(dac_vld), m_vld);
            check("cmp_done", int'(cycle_done), m_done);
            check("cmp_busy", int'(busy), (m_stage != 0) ? 1 : 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_gen(input int md, input int s, input int dv);
        mode = 2'(md);
        step_size = DATA_W'(s);
        step_div = DIV_W'(dv);
        en = 1'b1;
    endtask

    task automatic stop_gen();
        en = 1'b0;
        repeat (2) @(negedge s_clk);
    endtask

    task automatic wait_data(input string name, input int val, input int budget);
        int n = 0;
        do begin
            @(negedge s_clk);
            n++;
        end while (int'(dac_data) != val && n < budget);
        check(name, int'(dac_data), val);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        #12;
        check("rst_data", int'(dac_data), 0);
        check("rst_vld", int'(dac_vld), 0);
        check("rst_done", int'(cycle_done), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge s_clk);
        s_rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge s_clk);

        // Full sawtooth, update every cycle
        start_gen(0, 1, 0);
        @(negedge s_clk);
        check("t1_busy_load", int'(busy), 1);
        check("t1_no_vld_e0", int'(dac_vld), 0);
        @(negedge s_clk);
        check("t1_load_data", int'(dac_data), 0);
        check("t1_no_vld_e1", int'(dac_vld), 0);
        @(negedge s_clk);
        check("t1_first", int'(dac_data), 1);
        check("t1_first_vld", int'(dac_vld), 1);
        repeat (1022) @(negedge s_clk);
        check("t1_top", int'(dac_data), 1023);
        check("t1_top_nodone", int'(cycle_done), 0);
        @(negedge s_clk);
        check("t1_wrap", int'(dac_data), 0);
        check("t1_wrap_done", int'(cycle_done), 1);
        @(negedge s_clk);
        check("t1_after", int'(dac_data), 1);
        check("t1_after_done", int'(cycle_done), 0);
        en = 1'b0;
        @(negedge s_clk);
        check("t1_off_busy", int'(busy), 0);
        check("t1_off_data", int'(dac_data), 0);
        @(negedge s_clk);

        // Divided period: first update E0+6, then every 5 cycles
        start_gen(0, 1, 4);
        n = 0;
        do begin @(negedge s_clk); n++; end while (!dac_vld && n < 50);
        check("t2_latency", n, 7);
        check("t2_first", int'(dac_data), 1);
        @(negedge s_clk);
        check("t2_single", int'(dac_vld), 0);
        n = 1;
        do begin @(negedge s_clk); n++; end while (!dac_vld && n < 50);
        check("t2_period", n, 5);
        check("t2_second", int'(dac_data), 2);
        stop_gen();

        // Triangle with clamp at both ends
        start_gen(2, 256, 0);
        repeat (2) @(negedge s_clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge s_clk);
            check("t3_tri_data", int'(dac_data), tri_tbl[i]);
            check("t3_tri_done", int'(cycle_done), tri_done[i]);
        end
        stop_gen();

        // Step change takes effect only after the period completes
        start_gen(0, 1, 0);
        wait_data("t4_reach100", 100, 300);
        step_size = DATA_W'(2);
        step_div = DIV_W'(0);
        repeat (923) @(negedge s_clk);
        check("t4_top", int'(dac_data), 1023);
        @(negedge s_clk);
        check("t4_wrap", int'(dac_data), 0);
        check("t4_wrap_done", int'(cycle_done), 1);
        @(negedge s_clk);
        check("t4_step2a", int'(dac_data), 2);
        @(negedge s_clk);
        check("t4_step2b", int'(dac_data), 4);
        stop_gen();

        // en drop and async reset mid-run
        start_gen(0, 1, 0);
        wait_data("t5_reach500", 500, 700);
        en = 1'b0;
        @(negedge s_clk);
        check("t5_off_data", int'(dac_data), 0);
        check("t5_off_busy", int'(busy), 0);
        check("t5_off_vld", int'(dac_vld), 0);
        check("t5_off_done", int'(cycle_done), 0);
        start_gen(0, 3, 0);
        wait_data("t5_reach60", 60, 100);
        #2;
        s_rst_n = 1'b0;
        #1;
        check("t5_rst_data", int'(dac_data), 0);
        check("t5_rst_vld", int'(dac_vld), 0);
        check("t5_rst_busy", int'(busy), 0);
        en = 1'b0;
        @(negedge s_clk);
        s_rst_n = 1'b1;
        @(negedge s_clk);
        check("t5_post_vld", int'(dac_vld), 0);
        check("t5_post_busy", int'(busy), 0);
        @(negedge s_clk);

        // Saw down with borrow wrap
        start_gen(1, 100, 2);
        repeat (2) @(negedge s_clk);
        check("m1_load_max", int'(dac_data), 1023);
        n = 0;
        do begin @(negedge s_clk); n++; end while (!cycle_done && n < 200);
        check("m1_done_seen", int'(cycle_done), 1);
        check("m1_wrap", int'(dac_data), 947);
        stop_gen();

        // Square, S not a power of two; mode input changes mid-run are ignored
        start_gen(3, 300, 1);
        wait_data("m3_first_high", 1023, 100);
        check("m3_first_nodone", int'(cycle_done), 0);
        mode = 2'd0;
        repeat (40) @(negedge s_clk);
        stop_gen();

        // S=0: frozen code, strobe still pulses
        start_gen(0, 0, 1);
        repeat (30) @(negedge s_clk);
        check("s0_frozen", int'(dac_data), 0);
        stop_gen();

`ifdef DAC_WAVE_SYNC_EN
        start_gen(3, 512, 0);
        wait_data("sy_high", 1023, 20);
        sync_in = 1'b1;
        @(negedge s_clk);
        sync_in = 1'b0;
        check("sy_data0", int'(dac_data), 0);
        check("sy_novld", int'(dac_vld), 0);
        @(negedge s_clk);
        check("sy_tick1", int'(dac_data), 0);
        check("sy_tick1_vld", int'(dac_vld), 1);
        @(negedge s_clk);
        check("sy_tick2", int'(dac_data), 1023);
        stop_gen();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
